// File: rtl/bus_demo_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_demo_sequencer_pkg
// Brief   : Mode and state encodings shared by the demo bus sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package bus_demo_sequencer_pkg;

  localparam logic [1:0] MODE_READ   = 2'd0;
  localparam logic [1:0] MODE_WRITE  = 2'd1;
  localparam logic [1:0] MODE_VERIFY = 2'd2;

  localparam logic PASS_READ  = 1'b0;
  localparam logic PASS_WRITE = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_WAIT     = 3'd2,
    S_NEXT     = 3'd3,
    S_END_PASS = 3'd4,
    S_FIN      = 3'd5
  } state_t;

  // Mode 3 is reserved and behaves like a plain read sequence.
  function automatic logic first_pass_is_write(input logic [1:0] mode);
    return (mode == MODE_WRITE) || (mode == MODE_VERIFY);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_demo_watchdog.sv
`default_nettype none
// ============================================================================
// Module  : bus_demo_watchdog
// Brief   : Loadable down-counter; expired_o flags that the count reached zero.
// Revision: 1.0 - initial release
// ============================================================================
module bus_demo_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Loaded with TIMEOUT-1 so expiry lands on the TIMEOUT-th enabled cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(TIMEOUT - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/bus_demo_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : bus_demo_sequencer
// Brief   : Programmable write / read / write-then-verify burst sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module bus_demo_sequencer
  import bus_demo_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  ready,
  output logic                  done,
  output logic                  err,
  output logic [LEN_WIDTH-1:0]  err_count,
  output logic                  m_valid,
  output logic                  m_mode,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic                  m_ready,
  input  logic                  m_done,
  input  logic [DATA_WIDTH-1:0] m_rdata
);

  state_t                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    idx_q, idx_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [LEN_WIDTH-1:0]    err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [DATA_WIDTH-1:0]   seed_q, seed_d;
  logic [1:0]              mode_q, mode_d;
  logic                    pass_q, pass_d;
  logic                    err_q, err_d;
  logic                    ready_q, done_q, m_valid_q, m_mode_q;
  logic [ADDR_WIDTH-1:0]   m_addr_q;
  logic [DATA_WIDTH-1:0]   m_wdata_q;
  logic                    w_wd_load, w_wd_expired;
  logic [DATA_WIDTH-1:0]   w_exp_data;

  assign w_exp_data = seed_q ^ DATA_WIDTH'(idx_q);

  bus_demo_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rstn      (rstn),
    .load_i    (w_wd_load),
    .en_i      (state_q == S_WAIT),
    .expired_o (w_wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    base_d      = base_q;
    seed_d      = seed_q;
    mode_d      = mode_q;
    pass_d      = pass_q;
    err_d       = err_q;
    err_count_d = err_count_q;
    w_wd_load   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d      = mode;
          base_d      = base_addr;
          len_d       = len;
          seed_d      = seed;
          idx_d       = '0;
          err_d       = 1'b0;
          err_count_d = '0;
          pass_d      = first_pass_is_write(mode) ? PASS_WRITE : PASS_READ;
          state_d     = (len == '0) ? S_FIN : S_REQ;
        end
      end
      S_REQ: begin
        if (m_valid_q && m_ready) begin
          w_wd_load = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        // m_done takes priority over a watchdog expiring in the same cycle.
        if (m_done) begin
          if ((pass_q == PASS_READ) && (m_rdata != w_exp_data)) begin
            err_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + LEN_WIDTH'(1);
            end
          end
          state_d = S_NEXT;
        end else if (w_wd_expired) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end
      end
      S_NEXT: begin
        if (idx_q == (len_q - LEN_WIDTH'(1))) begin
          state_d = S_END_PASS;
        end else begin
          idx_d   = idx_q + LEN_WIDTH'(1);
          state_d = S_REQ;
        end
      end
      S_END_PASS: begin
        if ((mode_q == MODE_VERIFY) && (pass_q == PASS_WRITE)) begin
          pass_d  = PASS_READ;
          idx_d   = '0;
          state_d = S_REQ;
        end else begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      base_q      <= '0;
      seed_q      <= '0;
      mode_q      <= MODE_READ;
      pass_q      <= PASS_READ;
      err_q       <= 1'b0;
      err_count_q <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      m_valid_q   <= 1'b0;
      m_mode_q    <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      base_q      <= base_d;
      seed_q      <= seed_d;
      mode_q      <= mode_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      ready_q     <= (state_d == S_IDLE);
      done_q      <= (state_d == S_FIN);
      m_valid_q   <= (state_d == S_REQ);
      if (state_d == S_REQ) begin
        m_mode_q  <= pass_d;
        m_addr_q  <= base_d + ADDR_WIDTH'(idx_d);
        m_wdata_q <= seed_d ^ DATA_WIDTH'(idx_d);
      end
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign m_valid   = m_valid_q;
  assign m_mode    = m_mode_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_demo_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_demo_sequencer
// Brief   : Scoreboard bench for bus_demo_sequencer with a bus memory model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bus_demo_sequencer;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int LW  = 8;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [1:0]    mode;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len;
  logic [DW-1:0] seed;
  logic          ready, done, err;
  logic [LW-1:0] err_count;
  logic          m_valid, m_mode;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ready, m_done;
  logic [DW-1:0] m_rdata;

  always #5 clk = ~clk;

  bus_demo_sequencer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .TIMEOUT    (TMO)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .mode      (mode),
    .base_addr (base_addr),
    .len       (len),
    .seed      (seed),
    .ready     (ready),
    .done      (done),
    .err       (err),
    .err_count (err_count),
    .m_valid   (m_valid),
    .m_mode    (m_mode),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_ready   (m_ready),
    .m_done    (m_done),
    .m_rdata   (m_rdata)
  );

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  // lat_kind: 0 none, 1 done one cycle after start, 2 done TMO+1 after accept
  typedef struct {
    bit            err;
    logic [LW-1:0] cnt;
    int            lat_kind;
  } res_t;

  req_t exp_req_q[$];
  res_t exp_res_q[$];

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [DW-1:0] mem [0:65535];

  int lat_fixed   = 0;
  bit never_done  = 0;
  int corrupt_idx = -1;
  int rd_idx      = 0;

  int cyc = 0, n_done = 0, n_acc = 0, start_cyc = 0, acc_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      passes++;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit   prev_done = 0;
  bit   hold_pend = 0;
  req_t hold_r;
  req_t mon_r;
  res_t mon_e;

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      hold_pend = 0;
      prev_done = 0;
    end else begin
      if (start && ready) start_cyc = cyc;
      if (hold_pend) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_addr", 32'(m_addr), 32'(hold_r.addr));
        check("hold_mode", 32'(m_mode), 32'(hold_r.wr));
        if (hold_r.wr) check("hold_wdata", 32'(m_wdata), 32'(hold_r.data));
      end
      hold_pend   = m_valid && !m_ready;
      hold_r.wr   = m_mode;
      hold_r.addr = m_addr;
      hold_r.data = m_wdata;
      if (m_valid && m_ready) begin
        n_acc++;
        acc_cyc = cyc;
        if (exp_req_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_req: addr 0x%0h mode %0d, none expected", m_addr, m_mode);
        end else begin
          mon_r = exp_req_q.pop_front();
          check("req_mode", 32'(m_mode), 32'(mon_r.wr));
          check("req_addr", 32'(m_addr), 32'(mon_r.addr));
          if (mon_r.wr) check("req_wdata", 32'(m_wdata), 32'(mon_r.data));
        end
      end
      if (prev_done) check("ready_after_done", 32'(ready), 32'd1);
      if (done) begin
        n_done++;
        check("done_single_cycle", 32'(prev_done), 32'd0);
        if (exp_res_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done: done with no sequence pending, got 1 expected 0");
        end else begin
          mon_e = exp_res_q.pop_front();
          check("err", 32'(err), 32'(mon_e.err));
          check("err_count", 32'(err_count), 32'(mon_e.cnt));
          check("reqs_outstanding", 32'(exp_req_q.size()), 32'd0);
          if (mon_e.lat_kind == 1) check("done_lat_from_start", 32'(cyc - start_cyc), 32'd1);
          if (mon_e.lat_kind == 2) check("done_lat_from_accept", 32'(cyc - acc_cyc), 32'(TMO + 1));
        end
      end
      prev_done = done;
    end
  end

  // ---------------- bus master / memory model ----------------
  initial begin : master
    bit            hs, h_wr, pend, p_wr, p_bad;
    logic [AW-1:0] h_addr, p_addr;
    logic [DW-1:0] h_wdata;
    int            lat;
    m_ready = 1'b0; m_done = 1'b0; m_rdata = '0;
    pend = 0; p_wr = 0; p_bad = 0; p_addr = '0; lat = 0;
    forever begin
      @(negedge clk);
      hs      = rstn && m_valid && m_ready;
      h_wr    = m_mode;
      h_addr  = m_addr;
      h_wdata = m_wdata;
      if (!rstn) pend = 0;
      @(posedge clk);
      #1;
      m_done  = 1'b0;
      m_rdata = DW'($urandom);
      if (hs) begin
        p_addr = h_addr;
        p_wr   = h_wr;
        p_bad  = 0;
        if (h_wr) begin
          mem[h_addr] = h_wdata;
        end else begin
          p_bad = (rd_idx == corrupt_idx);
          rd_idx++;
        end
        pend = !never_done;
        lat  = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 5));
      end
      if (pend) begin
        lat--;
        if (lat == 0) begin
          pend   = 0;
          m_done = 1'b1;
          if (!p_wr) m_rdata = mem[p_addr] ^ (p_bad ? 8'h5A : 8'h00);
        end
      end else if (!hs && !never_done && ($urandom_range(0, 7) == 0)) begin
        m_done = 1'b1;  // stray pulse outside WAIT must be ignored
      end
      m_ready = !pend && ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- reference model + stimulus ----------------
  task automatic issue_seq(input logic [1:0] md, input logic [AW-1:0] b, input logic [LW-1:0] l,
                           input logic [DW-1:0] s, input int corrupt, input bit tmo);
    req_t r;
    res_t e;
    int   npass, errs, k;
    bit   first_wr;
    first_wr = (md == 2'd1) || (md == 2'd2);
    npass    = (md == 2'd2) ? 2 : 1;
    errs     = 0;
    for (int p = 0; p < npass; p++) begin
      for (int i = 0; i < int'(l); i++) begin
        r.wr   = first_wr && (p == 0);
        r.addr = AW'(int'(b) + i);  // address window wraps modulo 2^AW
        r.data = s ^ DW'(i);
        if (!tmo || (p == 0 && i == 0)) exp_req_q.push_back(r);
        if (!tmo && !r.wr) begin
          if (md == 2'd2) begin
            if (i == corrupt) errs++;
          end else if (mem[r.addr] != r.data) begin
            errs++;
          end
        end
      end
    end
    e.err      = tmo || (errs > 0);
    e.cnt      = (errs > 255) ? 8'hFF : LW'(errs);
    e.lat_kind = tmo ? 2 : ((l == '0) ? 1 : 0);
    exp_res_q.push_back(e);

    k = 0;
    while (!ready && k < 200) begin
      @(posedge clk); #1; k++;
    end
    corrupt_idx = corrupt;
    rd_idx      = 0;
    start = 1'b1; mode = md; base_addr = b; len = l; seed = s;
    @(posedge clk); #1;
    start = 1'b0;
    mode = 2'($urandom); base_addr = AW'($urandom); len = LW'($urandom); seed = DW'($urandom);
  endtask

  task automatic run_seq(input logic [1:0] md, input logic [AW-1:0] b, input logic [LW-1:0] l,
                         input logic [DW-1:0] s, input int corrupt, input bit tmo);
    int n0, k;
    n0 = n_done;
    issue_seq(md, b, l, s, corrupt, tmo);
    k = 0;
    while (n_done == n0 && k < 5000) begin
      @(posedge clk); #1; k++;
    end
    check("done_seen", 32'(n_done - n0), 32'd1);
  endtask

  initial begin : stim
    int             n0, k, rl;
    logic [1:0]     md;
    logic [AW-1:0]  b;
    logic [DW-1:0]  s;
    rstn = 1'b0; start = 1'b0; mode = '0; base_addr = '0; len = '0; seed = '0;
    for (int a = 0; a < 65536; a++) mem[a] = DW'($urandom);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_mode", 32'(m_mode), 32'd0);
    check("rst_m_addr", 32'(m_addr), 32'd0);
    check("rst_m_wdata", 32'(m_wdata), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    lat_fixed = 3;
    run_seq(2'd1, 16'h3FFE, 8'd4, 8'hA5, -1, 0);
    lat_fixed = 0;
    run_seq(2'd2, 16'h0010, 8'd8, 8'h5A, -1, 0);
    run_seq(2'd2, 16'h0100, 8'd4, 8'h33, 2, 0);
    run_seq(2'd0, 16'h1234, 8'd0, 8'h11, -1, 0);
    run_seq(2'd1, 16'hFFFF, 8'd2, 8'h0F, -1, 0);

    // completion in the watchdog's final cycle still counts as success
    lat_fixed = TMO;
    run_seq(2'd1, 16'h0300, 8'd1, 8'h77, -1, 0);
    // one cycle later is a timeout, and the late m_done is ignored
    lat_fixed = TMO + 1;
    run_seq(2'd0, 16'h0310, 8'd1, 8'h88, -1, 1);

    lat_fixed  = 0;
    never_done = 1;
    run_seq(2'd1, 16'h0400, 8'd5, 8'h21, -1, 1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("no_valid_after_timeout", 32'(m_valid), 32'd0);
    end
    @(posedge clk); #1;
    never_done = 0;

    // every read mismatches: err_count must reach all-ones
    for (int i = 0; i < 255; i++) mem[16'h5000 + i] = ~(8'hC3 ^ DW'(i));
    lat_fixed = 1;
    run_seq(2'd3, 16'h5000, 8'd255, 8'hC3, -1, 0);
    lat_fixed = 0;

    for (int t = 0; t < 14; t++) begin
      md = 2'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? AW'(16'hFFF8 + $urandom_range(0, 7)) : AW'($urandom);
      rl = int'($urandom_range(0, 10));
      s  = DW'($urandom);
      if (md == 2'd0 || md == 2'd3) begin
        for (int i = 0; i < rl; i++)
          if ($urandom_range(0, 1) == 1) mem[AW'(int'(b) + i)] = s ^ DW'(i);
      end
      run_seq(md, b, LW'(rl), s,
              (md == 2'd2 && rl > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, rl - 1)) : -1, 0);
    end

    // reset while waiting on the third transfer of a mismatching read burst
    for (int i = 0; i < 8; i++) mem[16'h2000 + i] = ~(8'h44 ^ DW'(i));
    lat_fixed = 6;
    n0 = n_acc;
    issue_seq(2'd0, 16'h2000, 8'd8, 8'h44, -1, 0);
    k = 0;
    while (n_acc < n0 + 3 && k < 500) begin
      @(posedge clk); #1; k++;
    end
    check("reached_transfer3", 32'(n_acc - n0), 32'd3);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_req_q.delete();
    exp_res_q.delete();
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(ready), 32'd1);
    check("post_rst_m_valid", 32'(m_valid), 32'd0);
    check("post_rst_err_count", 32'(err_count), 32'd0);
    check("post_rst_err", 32'(err), 32'd0);
    check("post_rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    lat_fixed = 0;
    run_seq(2'd2, 16'h0700, 8'd3, 8'hE1, -1, 0);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_demo_sequencer.md
# bus_demo_sequencer

Parametrised transaction sequencer that drives one bus master port of the demo system. It replaces the single-shot start/mode demo control with a programmable burst of writes, reads, or write-then-read-verify passes over a contiguous address window. It sits between the board-level start/mode controls and the master-side request interface, and reports completion, mismatch count and timeout.

## Interface
- ADDR_WIDTH, 16, bus address width
- DATA_WIDTH, 8, bus data width
- LEN_WIDTH, 8, width of transfer-count input; max burst is 2^LEN_WIDTH-1 transfers
- TIMEOUT, 1024, cycles allowed between request acceptance and m_done before abort
- clk  in  1  system clock; all logic on rising edge
- rstn  in  1  reset, synchronous, active-low
- start  in  1  begin a sequence; sampled only in IDLE
- mode  in  2  0 read-only, 1 write-only, 2 write-then-verify, 3 reserved (treated as 0)
- base_addr  in  ADDR_WIDTH  first address
- len  in  LEN_WIDTH  number of transfers; 0 means finish immediately
- seed  in  DATA_WIDTH  data pattern seed
- ready  out  1  high in IDLE only
- done  out  1  one-cycle pulse on sequence end
- err  out  1  sticky: mismatch or timeout in the last sequence; cleared on next start
- err_count  out  LEN_WIDTH  mismatches in the last sequence, saturating
- m_valid  out  1  request valid
- m_mode  out  1  1 write, 0 read
- m_addr  out  ADDR_WIDTH  request address
- m_wdata  out  DATA_WIDTH  write data
- m_ready  in  1  master can accept a request
- m_done  in  1  one-cycle pulse when the accepted transfer completes
- m_rdata  in  DATA_WIDTH  read data; valid in the m_done cycle of a read

## Operation
- Pattern: data(i) = seed ^ i[DATA_WIDTH-1:0]; address(i) = base_addr + i, modulo 2^ADDR_WIDTH (wraps silently).
- start, mode, base_addr, len and seed are latched on the start cycle; later changes are ignored until IDLE.
- States:
  - IDLE: ready=1. On start, clear err and err_count, set i=0, set pass = (mode==0 or mode==3 ? READ : WRITE), and go to REQ. If len==0, go to FIN instead.
  - REQ: m_valid=1 with addr/data for index i. Go to WAIT on m_valid && m_ready, and load the watchdog.
  - WAIT: on m_done, a read compares m_rdata to data(i); a mismatch sets err and increments err_count, saturating at all-ones. Read-only mode also compares. Then go to NEXT. If the watchdog expires, set err and go to FIN.
  - NEXT: if i==len-1, go to END_PASS; otherwise increment i and go to REQ.
  - END_PASS: in mode 2 after the WRITE pass, set pass=READ, set i=0, go to REQ. Otherwise go to FIN.
  - FIN: done=1 for one cycle, then IDLE.
- An m_done arriving outside WAIT is ignored.
- Reset mid-sequence: abort immediately and return to IDLE with all outputs at reset values. No request is left asserted.

## Timing
- Reset values: ready=1 (IDLE), done=0, err=0, err_count=0, m_valid=0, m_mode=0, m_addr=0, m_wdata=0.
- All outputs are registered.
- start to first m_valid: 1 cycle.
- m_valid is held with stable addr/mode/wdata until the handshake cycle, then drops the next cycle.
- Per-transfer overhead beyond the master latency: REQ handshake cycle + m_done cycle + NEXT = at least 3 cycles.
- Watchdog counts TIMEOUT cycles in WAIT. An m_done that arrives in the same cycle the watchdog expires wins, and no timeout is recorded.
- The done pulse occurs on the FIN cycle; ready rises on the following cycle.

## Structure
- Shared package: mode encodings (MODE_READ, MODE_WRITE, MODE_VERIFY) and state encodings.
- Optional sub-module bus_demo_watchdog: a loadable down-counter with an expire flag.
- Everything else lives in one FSM module.

## Test plan
- Write-only: mode=1, base=0x3FFE, len=4, seed=0xA5, master latency 3.
  - Expect writes to 0x3FFE..0x4001 with data A5, A4, A7, A6.
  - Expect done once, err=0.
- Verify with a memory model: mode=2, base=0x0010, len=8, seed=0x5A.
  - Expect 8 writes, then 8 reads of the same addresses.
  - Expect err=0, err_count=0.
- Mismatch: mode=2, len=4, with the model corrupting the read at index 2.
  - Expect err=1, err_count=1, and all 4 reads still issued.
- Timeout: TIMEOUT=16, master never pulses m_done.
  - Expect err=1 and done 17 cycles after acceptance.
  - Expect no further m_valid.
- Edge cases:
  - len=0: done on the cycle after start, no m_valid.
  - base=0xFFFF, len=2: addresses 0xFFFF then 0x0000.
- Reset during WAIT of transfer 3: after rstn is released, the block is in IDLE, m_valid=0, ready=1, and err_count=0.
